// File: rtl/srl_cam_wr_ctrl_if.sv
// Command bus for the SRL32 CAM write controller.
// The master issues one entry-write or block-clear command with a valid/ready handshake.
interface srl_cam_wr_ctrl_if #(
    parameter int KEY_W = 40
);
    logic             wr_valid;
    logic             wr_ready;
    logic             wr_op;
    logic [2:0]       wr_addr;
    logic [KEY_W-1:0] wr_key;
    logic [KEY_W-1:0] wr_mask;

    modport master (
        output wr_valid,
        output wr_op,
        output wr_addr,
        output wr_key,
        output wr_mask,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_op,
        input  wr_addr,
        input  wr_key,
        input  wr_mask,
        output wr_ready
    );
endinterface

// File: rtl/srl_cam_wr_ctrl.sv
// Write controller for an SRL32-based CAM column group.
// Each accepted command produces 32 serial shift cycles (SRL address 31 first,
// 0 last), followed by a one-cycle done pulse. Every output is registered, so
// the next-state logic also computes the output values for the following cycle.
module srl_cam_wr_ctrl #(
    parameter  int KEY_W = 40,
    localparam int NCH   = KEY_W / 5
) (
    input  logic                   clk,
    input  logic                   rst,
    srl_cam_wr_ctrl_if.slave       cmd,
    output logic [7:0]             ce_demux,
    output logic                   flag,
    output logic                   wr_in,
    output logic [NCH-1:0]         srl_din,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [4:0]       cnt, cnt_next;
    logic             op_q, op_next;
    logic [2:0]       addr_q, addr_next;
    logic [KEY_W-1:0] key_q, key_next;
    logic [KEY_W-1:0] mask_q, mask_next;

    logic             ready_next;
    logic [7:0]       ce_next;
    logic             flag_next;
    logic             wr_in_next;
    logic [NCH-1:0]   din_next;
    logic             done_next;

    // One bit per chunk: 1 when the SRL address matches the chunk key on all unmasked bits.
    function automatic logic [NCH-1:0] match_bits(
        input logic [4:0]       addr,
        input logic [KEY_W-1:0] key,
        input logic [KEY_W-1:0] mask
    );
        logic [NCH-1:0] bits;
        bits = '0;
        for (int c = 0; c < NCH; c++) begin
            bits[c] = (((addr ^ key[5*c +: 5]) & ~mask[5*c +: 5]) == 5'd0);
        end
        return bits;
    endfunction

    // State, counter, latched command and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 5'd0;
            op_q         <= 1'b0;
            addr_q       <= 3'd0;
            key_q        <= '0;
            mask_q       <= '0;
            cmd.wr_ready <= 1'b0;
            ce_demux     <= 8'd0;
            flag         <= 1'b0;
            wr_in        <= 1'b0;
            srl_din      <= '0;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            op_q         <= op_next;
            addr_q       <= addr_next;
            key_q        <= key_next;
            mask_q       <= mask_next;
            cmd.wr_ready <= ready_next;
            ce_demux     <= ce_next;
            flag         <= flag_next;
            wr_in        <= wr_in_next;
            srl_din      <= din_next;
            done         <= done_next;
        end
    end

    // Next state, counter and the output values that will be visible next cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        op_next    = op_q;
        addr_next  = addr_q;
        key_next   = key_q;
        mask_next  = mask_q;
        ready_next = 1'b0;
        ce_next    = 8'd0;
        flag_next  = 1'b0;
        wr_in_next = 1'b0;
        din_next   = '0;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                ready_next = 1'b1;
                if (cmd.wr_valid && cmd.wr_ready) begin
                    state_next = SHIFT;
                    cnt_next   = 5'd31;
                    op_next    = cmd.wr_op;
                    addr_next  = cmd.wr_addr;
                    key_next   = cmd.wr_key;
                    mask_next  = cmd.wr_mask;
                    ready_next = 1'b0;
                    wr_in_next = 1'b1;
                    if (cmd.wr_op) begin
                        flag_next = 1'b1;
                    end else begin
                        ce_next  = 8'd1 << cmd.wr_addr;
                        din_next = match_bits(5'd31, cmd.wr_key, cmd.wr_mask);
                    end
                end
            end

            SHIFT: begin
                if (cnt == 5'd0) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    cnt_next   = cnt - 5'd1;
                    wr_in_next = 1'b1;
                    if (op_q) begin
                        flag_next = 1'b1;
                    end else begin
                        ce_next  = 8'd1 << addr_q;
                        din_next = match_bits(cnt - 5'd1, key_q, mask_q);
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
                ready_next = 1'b1;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
